// File: rtl/bsg_mul_cs_resolve_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_mul_cs_resolve_pkg
//  Purpose  : Shared types and helpers for the sequential carry-save
//             resolver: the controller state encoding and the slice-count
//             helper used to size the slice counter.
//  Contents : state_e        - IDLE / BUSY / DONE
//             slice_count()  - number of chunk-wide slices in a word
//  Revision : 1.0  initial release
// ============================================================================
package bsg_mul_cs_resolve_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int slice_count(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage : bsg_mul_cs_resolve_pkg
`default_nettype wire

// File: rtl/bsg_mul_cs_chunk_add.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_mul_cs_chunk_add
//  Purpose  : Purely combinational chunk_p-bit adder with carry in/out. Kept
//             as its own module so it can be swapped for a hardened adder.
//  Ports    : a_i   [chunk_p-1:0]  operand A
//             b_i   [chunk_p-1:0]  operand B
//             cr_i                 carry in
//             s_o   [chunk_p-1:0]  sum
//             cl_o                 carry out
//  Revision : 1.0  initial release
// ============================================================================
module bsg_mul_cs_chunk_add #(
    parameter int chunk_p = 8
) (
    input  logic [chunk_p-1:0] a_i,
    input  logic [chunk_p-1:0] b_i,
    input  logic               cr_i,
    output logic [chunk_p-1:0] s_o,
    output logic               cl_o
);

    logic [chunk_p:0] w_full;

    assign w_full = {1'b0, a_i} + {1'b0, b_i} + {{chunk_p{1'b0}}, cr_i};
    assign s_o    = w_full[chunk_p-1:0];
    assign cl_o   = w_full[chunk_p];

endmodule : bsg_mul_cs_chunk_add
`default_nettype wire

// File: rtl/bsg_mul_cs_resolve_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_mul_cs_resolve_seq
//  Purpose  : Resolves a carry-save pair (s_i, c_i, cr_i) into a binary sum
//             one chunk_p-bit slice per cycle, using a single shared chunk
//             adder selected by a slice counter. Result is presented with
//             valid/yumi and held until consumed.
//  Ports    : clk_i      clock
//             reset_n_i  asynchronous active-low reset
//             v_i        operands valid
//             ready_o    block can accept operands (IDLE only)
//             s_i        [width_p-1:0] sum vector
//             c_i        [width_p-1:0] carry vector (already weight-aligned)
//             cr_i       carry into bit 0
//             v_o        result valid
//             data_o     [width_p-1:0] low bits of s_i + c_i + cr_i
//             cl_o       carry out of bit width_p-1
//             yumi_i     consumer takes the result (only while v_o=1)
//  Revision : 1.0  initial release
// ============================================================================
module bsg_mul_cs_resolve_seq
    import bsg_mul_cs_resolve_pkg::*;
#(
    parameter int width_p = 32,
    parameter int chunk_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] s_i,
    input  logic [width_p-1:0] c_i,
    input  logic               cr_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               cl_o,
    input  logic               yumi_i
);

    localparam int N     = slice_count(width_p, chunk_p);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if ((chunk_p < 1) || ((width_p % chunk_p) != 0)) begin : g_bad_params
            $error("bsg_mul_cs_resolve_seq: width_p must be a positive multiple of chunk_p");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [width_p-1:0] s_q,     s_d;
    logic [width_p-1:0] c_q,     c_d;
    logic               carry_q, carry_d;
    logic [width_p-1:0] data_q,  data_d;
    logic               cl_q,    cl_d;
    logic               v_q,     v_d;
    logic               ready_q, ready_d;

    logic [chunk_p-1:0] w_a;
    logic [chunk_p-1:0] w_b;
    logic [chunk_p-1:0] w_sum;
    logic               w_cout;
    logic               w_last;

    // Slice mux: pick the chunk addressed by the counter. Written as a
    // constant-index loop so the selection stays clean for any N, including 1.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                w_a = s_q[i*chunk_p +: chunk_p];
                w_b = c_q[i*chunk_p +: chunk_p];
            end
        end
    end

    assign w_last = (cnt_q == CNT_W'(N - 1));

    bsg_mul_cs_chunk_add #(
        .chunk_p (chunk_p)
    ) u_chunk_add (
        .a_i  (w_a),
        .b_i  (w_b),
        .cr_i (carry_q),
        .s_o  (w_sum),
        .cl_o (w_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        c_d     = c_q;
        carry_d = carry_q;
        data_d  = data_q;
        cl_d    = cl_q;
        v_d     = v_q;
        ready_d = ready_q;

        case (state_q)
            IDLE: begin
                // ready_q is 1 throughout IDLE, so v_i alone qualifies accept.
                if (v_i) begin
                    s_d     = s_i;
                    c_d     = c_i;
                    carry_d = cr_i;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                for (int i = 0; i < N; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        data_d[i*chunk_p +: chunk_p] = w_sum;
                    end
                end
                carry_d = w_cout;
                if (w_last) begin
                    cnt_d   = '0;
                    cl_d    = w_cout;
                    v_d     = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                // No bypass: ready only rises on the cycle after consumption.
                if (yumi_i) begin
                    v_d     = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                v_d     = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            c_q     <= '0;
            carry_q <= 1'b0;
            data_q  <= '0;
            cl_q    <= 1'b0;
            v_q     <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            data_q  <= data_d;
            cl_q    <= cl_d;
            v_q     <= v_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign v_o     = v_q;
    assign data_o  = data_q;
    assign cl_o    = cl_q;

`ifndef SYNTHESIS
    // Consuming a result that is not being offered is a protocol error.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && yumi_i) begin
            assert (v_q) else $error("bsg_mul_cs_resolve_seq: yumi_i asserted while v_o=0");
        end
    end
`endif

endmodule : bsg_mul_cs_resolve_seq
`default_nettype wire

// File: tb/tb_bsg_mul_cs_resolve_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bsg_mul_cs_resolve_seq
//  Purpose  : Directed self-checking bench for bsg_mul_cs_resolve_seq at
//             width_p=32, chunk_p=8 (four slices).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bsg_mul_cs_resolve_seq;

    localparam int W = 32;

    logic          clk_i;
    logic          reset_n_i;
    logic          v_i;
    logic          ready_o;
    logic [W-1:0]  s_i;
    logic [W-1:0]  c_i;
    logic          cr_i;
    logic          v_o;
    logic [W-1:0]  data_o;
    logic          cl_o;
    logic          yumi_i;

    int n_cmp;
    int n_mis;

    bsg_mul_cs_resolve_seq #(
        .width_p (32),
        .chunk_p (8)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .s_i       (s_i),
        .c_i       (c_i),
        .cr_i      (cr_i),
        .v_o       (v_o),
        .data_o    (data_o),
        .cl_o      (cl_o),
        .yumi_i    (yumi_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands and hold v_i until the edge that accepts them.
    // Returns just after the acceptance edge.
    task automatic accept(input logic [W-1:0] s, input logic [W-1:0] c, input logic cr);
        int t;
        @(negedge clk_i);
        v_i  = 1'b1;
        s_i  = s;
        c_i  = c;
        cr_i = cr;
        t = 0;
        while (!ready_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        chk("accept_timeout", {32'd0, ready_o}, 33'd1);
        @(posedge clk_i);
        #1;
        v_i  = 1'b0;
        s_i  = $urandom;
        c_i  = $urandom;
        cr_i = 1'($urandom);
    endtask

    // One full transaction: accept, check 4-cycle latency, hold for ydly
    // cycles with junk on the inputs, then consume and check the return to IDLE.
    task automatic run_op(input string tag, input logic [W-1:0] s, input logic [W-1:0] c,
                          input logic cr, input int ydly);
        logic [32:0] exp;
        exp = {1'b0, s} + {1'b0, c} + {32'd0, cr};
        accept(s, c, cr);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk_i);
            #1;
            chk({tag, "_busy_v"},     {32'd0, v_o},     33'd0);
            chk({tag, "_busy_ready"}, {32'd0, ready_o}, 33'd0);
            v_i = 1'($urandom);
            s_i = $urandom;
        end
        @(posedge clk_i);
        #1;
        chk({tag, "_v"},      {32'd0, v_o},     33'd1);
        chk({tag, "_result"}, {cl_o, data_o},   exp);
        for (int d = 0; d < ydly; d++) begin
            v_i  = 1'($urandom);
            s_i  = $urandom;
            c_i  = $urandom;
            cr_i = 1'($urandom);
            @(posedge clk_i);
            #1;
            chk({tag, "_hold_result"}, {cl_o, data_o},   exp);
            chk({tag, "_hold_ready"},  {32'd0, ready_o}, 33'd0);
            chk({tag, "_hold_v"},      {32'd0, v_o},     33'd1);
        end
        v_i    = 1'b0;
        yumi_i = 1'b1;
        @(posedge clk_i);
        #1;
        yumi_i = 1'b0;
        chk({tag, "_post_ready"}, {32'd0, ready_o}, 33'd1);
        chk({tag, "_post_v"},     {32'd0, v_o},     33'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_mis     = 0;
        reset_n_i = 1'b0;
        v_i       = 1'b0;
        yumi_i    = 1'b0;
        s_i       = '0;
        c_i       = '0;
        cr_i      = 1'b0;

        // Reset state
        #12;
        chk("rst_v",     {32'd0, v_o},     33'd0);
        chk("rst_ready", {32'd0, ready_o}, 33'd1);
        chk("rst_data",  {cl_o, data_o},   33'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // Directed arithmetic cases
        run_op("basic",     32'h0000_0001, 32'h0000_00FF, 1'b0, 0);  // 0x0_00000100
        run_op("ripple",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);  // 0x1_00000000
        run_op("max",       32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1);  // 0x1_FFFFFFFF
        run_op("msb_carry", 32'h8000_0000, 32'h8000_0000, 1'b0, 0);  // 0x1_00000000
        run_op("alt_ripple",32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 2);  // 0x1_00000000
        run_op("zero",      32'h0000_0000, 32'h0000_0000, 1'b0, 0);  // 0x0_00000000

        // Backpressure: hold 10 cycles in DONE with toggling inputs
        run_op("bp", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 10);       // 0x0_FFFFFFFF
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i);
            #1;
            chk("bp_no_accept_v",     {32'd0, v_o},     33'd0);
            chk("bp_no_accept_ready", {32'd0, ready_o}, 33'd1);
        end

        // Reset mid-operation after two BUSY edges
        accept(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        chk("midrst_busy_ready", {32'd0, ready_o}, 33'd0);
        reset_n_i = 1'b0;
        #1;
        chk("midrst_v",     {32'd0, v_o},     33'd0);
        chk("midrst_ready", {32'd0, ready_o}, 33'd1);
        chk("midrst_data",  {cl_o, data_o},   33'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        run_op("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 0); // 0x0_23456789

        // Random operands, random idle gaps and consume delays
        for (int n = 0; n < 200; n++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk_i);
                #1;
                chk("rand_idle_v", {32'd0, v_o}, 33'd0);
            end
            run_op("rand", $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_bsg_mul_cs_resolve_seq
`default_nettype wire
